idex_stage: RTL

IDEX_STAGE -- requirements
Module: idex_stage

---
 rtl/idex_stage_if.sv | 58 +++++
 rtl/idex_stage.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/idex_stage_if.sv
// ID/EX pipeline bundle: ID-stage inputs toward the register, registered EX-side
// outputs and the hazard/enable flags back toward the front end.
interface idex_stage_if;
    logic        RegWrite_i;
    logic        MemToReg_i;
    logic        MemRead_i;
    logic        MemWrite_i;
    logic        ALUSrc_i;
    logic        RegDst_i;
    logic [1:0]  ALUOp_i;
    logic [31:0] RSdata_i;
    logic [31:0] RTdata_i;
    logic [31:0] Imm_i;
    logic [4:0]  IFID_Rs_i;
    logic [4:0]  IFID_Rt_i;
    logic [4:0]  IFID_Rd_i;
    logic        Flush_i;
    logic        MemStall_i;

    logic        IDEX_RegWrite_o;
    logic        IDEX_MemToReg_o;
    logic        IDEX_MemRead_o;
    logic        IDEX_MemWrite_o;
    logic        IDEX_ALUSrc_o;
    logic        IDEX_RegDst_o;
    logic [1:0]  IDEX_ALUOp_o;
    logic [31:0] IDEX_RSdata_o;
    logic [31:0] IDEX_RTdata_o;
    logic [31:0] IDEX_Imm_o;
    logic [4:0]  IDEX_Rs_o;
    logic [4:0]  IDEX_Rt_o;
    logic [4:0]  IDEX_Rd_o;
    logic        Valid_o;
    logic        Hazard_o;
    logic        PCWrite_o;
    logic        IFIDWrite_o;
    logic [15:0] BubbleCnt_o;

    modport master (
        output RegWrite_i, MemToReg_i, MemRead_i, MemWrite_i, ALUSrc_i, RegDst_i,
               ALUOp_i, RSdata_i, RTdata_i, Imm_i, IFID_Rs_i, IFID_Rt_i, IFID_Rd_i,
               Flush_i, MemStall_i,
        input  IDEX_RegWrite_o, IDEX_MemToReg_o, IDEX_MemRead_o, IDEX_MemWrite_o,
               IDEX_ALUSrc_o, IDEX_RegDst_o, IDEX_ALUOp_o, IDEX_RSdata_o,
               IDEX_RTdata_o, IDEX_Imm_o, IDEX_Rs_o, IDEX_Rt_o, IDEX_Rd_o,
               Valid_o, Hazard_o, PCWrite_o, IFIDWrite_o, BubbleCnt_o
    );

    modport slave (
        input  RegWrite_i, MemToReg_i, MemRead_i, MemWrite_i, ALUSrc_i, RegDst_i,
               ALUOp_i, RSdata_i, RTdata_i, Imm_i, IFID_Rs_i, IFID_Rt_i, IFID_Rd_i,
               Flush_i, MemStall_i,
        output IDEX_RegWrite_o, IDEX_MemToReg_o, IDEX_MemRead_o, IDEX_MemWrite_o,
               IDEX_ALUSrc_o, IDEX_RegDst_o, IDEX_ALUOp_o, IDEX_RSdata_o,
               IDEX_RTdata_o, IDEX_Imm_o, IDEX_Rs_o, IDEX_Rt_o, IDEX_Rd_o,
               Valid_o, Hazard_o, PCWrite_o, IFIDWrite_o, BubbleCnt_o
    );
endinterface

// File: rtl/idex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush/stall handling
// and a saturating count of hazard bubbles.
module idex_stage (
    input  logic         clk_i,
    input  logic         rst_i,
    idex_stage_if.slave  bus
);
    logic        reg_write_q, reg_write_d;
    logic        mem_to_reg_q, mem_to_reg_d;
    logic        mem_read_q, mem_read_d;
    logic        mem_write_q, mem_write_d;
    logic        alu_src_q, alu_src_d;
    logic        reg_dst_q, reg_dst_d;
    logic [1:0]  alu_op_q, alu_op_d;
    logic [31:0] rs_data_q, rs_data_d;
    logic [31:0] rt_data_q, rt_data_d;
    logic [31:0] imm_q, imm_d;
    logic [4:0]  rs_q, rs_d;
    logic [4:0]  rt_q, rt_d;
    logic [4:0]  rd_q, rd_d;
    logic        valid_q, valid_d;
    logic [15:0] bubble_cnt_q, bubble_cnt_d;

    logic hazard;
    logic rt_match;

    // Register 0 is hard-wired, so a load targeting it never creates a dependency.
    always_comb begin
        rt_match = (rt_q == bus.IFID_Rs_i) || (rt_q == bus.IFID_Rt_i);
        hazard   = mem_read_q && (rt_q != 5'd0) && rt_match;
    end

    always_comb begin
        reg_write_d  = reg_write_q;
        mem_to_reg_d = mem_to_reg_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        alu_src_d    = alu_src_q;
        reg_dst_d    = reg_dst_q;
        alu_op_d     = alu_op_q;
        rs_data_d    = rs_data_q;
        rt_data_d    = rt_data_q;
        imm_d        = imm_q;
        rs_d         = rs_q;
        rt_d         = rt_q;
        rd_d         = rd_q;
        valid_d      = valid_q;
        bubble_cnt_d = bubble_cnt_q;

        if (bus.MemStall_i) begin
            // freeze: defaults already hold every register
        end else if (bus.Flush_i || hazard) begin
            reg_write_d  = 1'b0;
            mem_to_reg_d = 1'b0;
            mem_read_d   = 1'b0;
            mem_write_d  = 1'b0;
            alu_src_d    = 1'b0;
            reg_dst_d    = 1'b0;
            alu_op_d     = 2'b00;
            rs_data_d    = 32'd0;
            rt_data_d    = 32'd0;
            imm_d        = 32'd0;
            rs_d         = 5'd0;
            rt_d         = 5'd0;
            rd_d         = 5'd0;
            valid_d      = 1'b0;
            // Only hazard bubbles are counted; a flush wins the attribution.
            if (hazard && !bus.Flush_i && (bubble_cnt_q != 16'hFFFF)) begin
                bubble_cnt_d = bubble_cnt_q + 16'd1;
            end
        end else begin
            reg_write_d  = bus.RegWrite_i;
            mem_to_reg_d = bus.MemToReg_i;
            mem_read_d   = bus.MemRead_i;
            mem_write_d  = bus.MemWrite_i;
            alu_src_d    = bus.ALUSrc_i;
            reg_dst_d    = bus.RegDst_i;
            alu_op_d     = bus.ALUOp_i;
            rs_data_d    = bus.RSdata_i;
            rt_data_d    = bus.RTdata_i;
            imm_d        = bus.Imm_i;
            rs_d         = bus.IFID_Rs_i;
            rt_d         = bus.IFID_Rt_i;
            rd_d         = bus.IFID_Rd_i;
            valid_d      = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            alu_src_q    <= 1'b0;
            reg_dst_q    <= 1'b0;
            alu_op_q     <= 2'b00;
            rs_data_q    <= 32'd0;
            rt_data_q    <= 32'd0;
            imm_q        <= 32'd0;
            rs_q         <= 5'd0;
            rt_q         <= 5'd0;
            rd_q         <= 5'd0;
            valid_q      <= 1'b0;
            bubble_cnt_q <= 16'd0;
        end else begin
            reg_write_q  <= reg_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            alu_src_q    <= alu_src_d;
            reg_dst_q    <= reg_dst_d;
            alu_op_q     <= alu_op_d;
            rs_data_q    <= rs_data_d;
            rt_data_q    <= rt_data_d;
            imm_q        <= imm_d;
            rs_q         <= rs_d;
            rt_q         <= rt_d;
            rd_q         <= rd_d;
            valid_q      <= valid_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    // Flush does not gate the front end: the redirect target must still load.
    always_comb begin
        bus.Hazard_o        = hazard;
        bus.PCWrite_o       = !(hazard || bus.MemStall_i);
        bus.IFIDWrite_o     = !(hazard || bus.MemStall_i);
        bus.IDEX_RegWrite_o = reg_write_q;
        bus.IDEX_MemToReg_o = mem_to_reg_q;
        bus.IDEX_MemRead_o  = mem_read_q;
        bus.IDEX_MemWrite_o = mem_write_q;
        bus.IDEX_ALUSrc_o   = alu_src_q;
        bus.IDEX_RegDst_o   = reg_dst_q;
        bus.IDEX_ALUOp_o    = alu_op_q;
        bus.IDEX_RSdata_o   = rs_data_q;
        bus.IDEX_RTdata_o   = rt_data_q;
        bus.IDEX_Imm_o      = imm_q;
        bus.IDEX_Rs_o       = rs_q;
        bus.IDEX_Rt_o       = rt_q;
        bus.IDEX_Rd_o       = rd_q;
        bus.Valid_o         = valid_q;
        bus.BubbleCnt_o     = bubble_cnt_q;
    end
endmodule
